// File: rtl/mem_if_pkg.sv
// Shared types for the 128-bit line memory interface.
// Latency: n/a (types, parameters and a helper only).
// Backpressure: n/a.
package mem_if_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 32;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        WB_ISSUE,
        WB_WAIT,
        RD_ISSUE,
        RD_WAIT,
        RESP
    } req_state_t;

    // Clear the byte-offset bits so the address points at the start of its line.
    function automatic addr_t line_align(input addr_t addr, input int unsigned line_bytes);
        return addr & ~addr_t'(line_bytes - 1);
    endfunction

endpackage

// File: rtl/cache_mem_requester_if.sv
// Bundle of the cache-side request/response and memory-side line signals.
// Latency: n/a (wiring only).
// Backpressure: carried by out_req_ready (cache side) and in_mem_ready (memory side).
interface cache_mem_requester_if;
    import mem_if_pkg::*;

    logic  in_req_valid;
    logic  out_req_ready;
    addr_t in_req_addr;
    logic  in_req_dirty;
    addr_t in_victim_addr;
    line_t in_victim_data;
    logic  out_resp_valid;
    line_t out_resp_data;
    logic  out_mem_read_en;
    logic  out_mem_write_en;
    addr_t out_mem_addr;
    line_t out_mem_write_data;
    logic  in_mem_ready;
    line_t in_mem_read_data;
    logic  out_timeout_err;

    // The requester block itself.
    modport master (
        input  in_req_valid, in_req_addr, in_req_dirty, in_victim_addr, in_victim_data,
        input  in_mem_ready, in_mem_read_data,
        output out_req_ready, out_resp_valid, out_resp_data,
        output out_mem_read_en, out_mem_write_en, out_mem_addr, out_mem_write_data,
        output out_timeout_err
    );

    // The cache and memory surrounding it.
    modport slave (
        output in_req_valid, in_req_addr, in_req_dirty, in_victim_addr, in_victim_data,
        output in_mem_ready, in_mem_read_data,
        input  out_req_ready, out_resp_valid, out_resp_data,
        input  out_mem_read_en, out_mem_write_en, out_mem_addr, out_mem_write_data,
        input  out_timeout_err
    );

endinterface

// File: rtl/cache_mem_requester.sv
// Miss handler memory port: optional victim writeback, then line refill returned to the cache.
// Latency: accept -> resp_valid = 1 + mem latency + 1, plus (1 + mem latency) when a writeback is needed.
// Backpressure: one request at a time; out_req_ready only in IDLE, waits on in_mem_ready indefinitely.
module cache_mem_requester
    import mem_if_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int TIMEOUT    = 64
) (
    input logic clk,
    input logic reset,
    cache_mem_requester_if.master bus
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    req_state_t       state;
    addr_t            refill_addr;
    logic [CNT_W-1:0] wait_cnt;

    logic  req_ready;
    logic  resp_valid;
    line_t resp_data;
    logic  mem_read_en;
    logic  mem_write_en;
    addr_t mem_addr;
    line_t mem_write_data;
    logic  timeout_err;

    assign bus.out_req_ready      = req_ready;
    assign bus.out_resp_valid     = resp_valid;
    assign bus.out_resp_data      = resp_data;
    assign bus.out_mem_read_en    = mem_read_en;
    assign bus.out_mem_write_en   = mem_write_en;
    assign bus.out_mem_addr       = mem_addr;
    assign bus.out_mem_write_data = mem_write_data;
    assign bus.out_timeout_err    = timeout_err;

    // Request FSM with registered outputs; the en pulses and resp_valid default low every cycle
    // so each is high for exactly the one cycle in which it is set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            refill_addr    <= '0;
            wait_cnt       <= '0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_data      <= '0;
            mem_read_en    <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            timeout_err    <= 1'b0;
        end else begin
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            resp_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_req_valid) begin
                        req_ready   <= 1'b0;
                        refill_addr <= line_align(bus.in_req_addr, LINE_BYTES);
                        wait_cnt    <= '0;
                        if (bus.in_req_dirty) begin
                            state          <= WB_ISSUE;
                            mem_write_en   <= 1'b1;
                            mem_addr       <= line_align(bus.in_victim_addr, LINE_BYTES);
                            mem_write_data <= bus.in_victim_data;
                        end else begin
                            state       <= RD_ISSUE;
                            mem_read_en <= 1'b1;
                            mem_addr    <= line_align(bus.in_req_addr, LINE_BYTES);
                        end
                    end
                end
                WB_ISSUE: begin
                    state    <= WB_WAIT;
                    wait_cnt <= '0;
                end
                WB_WAIT: begin
                    if (bus.in_mem_ready) begin
                        state       <= RD_ISSUE;
                        mem_read_en <= 1'b1;
                        mem_addr    <= refill_addr;
                        wait_cnt    <= '0;
                    end else begin
                        if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == CNT_LAST) timeout_err <= 1'b1;
                    end
                end
                RD_ISSUE: begin
                    state    <= RD_WAIT;
                    wait_cnt <= '0;
                end
                RD_WAIT: begin
                    if (bus.in_mem_ready) begin
                        state      <= RESP;
                        resp_data  <= bus.in_mem_read_data;
                        resp_valid <= 1'b1;
                    end else begin
                        if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == CNT_LAST) timeout_err <= 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_requester.sv
// Bench for cache_mem_requester: stub memory with programmable latency, scoreboard of expected ops/refills.
// Latency: checks accept-to-response cycle counts against the nominal formula.
// Backpressure: exercises held requests while busy and a memory that never answers.
module tb_cache_mem_requester;
    import mem_if_pkg::*;

    localparam int TO = 64;
    localparam int LB = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_mem_requester_if bus();

    cache_mem_requester #(.LINE_BYTES(LB), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic  wr;
        addr_t addr;
        line_t data;
    } op_t;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    line_t mem     [addr_t];
    line_t ref_mem [addr_t];
    op_t   exp_ops [$];
    line_t exp_resp[$];
    addr_t pool    [8];

    int    lat      = 12;
    bit    mem_dead = 1'b0;
    bit    spur     = 1'b0;
    bit    pend     = 1'b0;
    bit    pend_wr  = 1'b0;
    addr_t pend_addr;
    line_t pend_data;
    int    cd       = 0;
    bit    prev_en  = 1'b0;
    bit    prev_rv  = 1'b0;
    int    n_rd = 0, n_wr = 0, n_resp = 0;
    int    last_rd_cyc = -1, last_resp_cyc = -1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic line_t mem_rd(input addr_t a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    function automatic line_t ref_rd(input addr_t a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return '0;
    endfunction

    function automatic addr_t to_line(input addr_t a);
        return {a[31:4], 4'h0};
    endfunction

    // One clock: sample at the falling edge, score DUT activity, drive the stub memory.
    task automatic tick();
        op_t e;
        @(negedge clk);
        cyc++;
        bus.in_mem_ready     = spur;
        spur                 = 1'b0;
        bus.in_mem_read_data = {$urandom, $urandom, $urandom, $urandom};
        if (!reset) begin
            pend    = 1'b0;
            prev_en = 1'b0;
            prev_rv = 1'b0;
            return;
        end
        if (bus.out_mem_read_en || bus.out_mem_write_en) begin
            check("en_exclusive", 128'(bus.out_mem_read_en & bus.out_mem_write_en), 128'(0));
            check("en_one_cycle", 128'(prev_en), 128'(0));
            check("en_while_busy", 128'(pend), 128'(0));
            if (exp_ops.size() == 0) begin
                check("unexpected_en", 128'(1), 128'(0));
            end else begin
                e = exp_ops.pop_front();
                check("en_kind", 128'(bus.out_mem_write_en), 128'(e.wr));
                check("en_addr", 128'(bus.out_mem_addr), 128'(e.addr));
                if (e.wr) check("wb_data", bus.out_mem_write_data, e.data);
            end
            pend      = 1'b1;
            pend_wr   = bus.out_mem_write_en;
            pend_addr = bus.out_mem_addr;
            pend_data = bus.out_mem_write_data;
            cd        = lat;
            if (bus.out_mem_read_en) begin
                n_rd++;
                last_rd_cyc = cyc;
            end else begin
                n_wr++;
            end
        end else if (pend) begin
            check("addr_held", 128'(bus.out_mem_addr), 128'(pend_addr));
            if (pend_wr) check("wdata_held", bus.out_mem_write_data, pend_data);
            cd--;
            if (cd <= 0 && !mem_dead) begin
                bus.in_mem_ready = 1'b1;
                if (pend_wr) mem[pend_addr] = pend_data;
                else bus.in_mem_read_data = mem_rd(pend_addr);
                pend = 1'b0;
            end
        end
        prev_en = bus.out_mem_read_en | bus.out_mem_write_en;
        if (bus.out_resp_valid) begin
            check("resp_one_cycle", 128'(prev_rv), 128'(0));
            if (exp_resp.size() == 0) check("unexpected_resp", 128'(1), 128'(0));
            else check("resp_data", bus.out_resp_data, exp_resp.pop_front());
            n_resp++;
            last_resp_cyc = cyc;
        end
        prev_rv = bus.out_resp_valid;
    endtask

    // Queue the reference model's expectations for one miss.
    task automatic model_req(input addr_t ra, input bit d, input addr_t va, input line_t vd);
        if (d) begin
            exp_ops.push_back('{1'b1, to_line(va), vd});
            ref_mem[to_line(va)] = vd;
        end
        exp_ops.push_back('{1'b0, to_line(ra), '0});
        exp_resp.push_back(ref_rd(to_line(ra)));
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!bus.out_req_ready && guard < 500) begin
            tick();
            guard++;
        end
        check("req_ready_wait", 128'(bus.out_req_ready), 128'(1));
    endtask

    task automatic drive_req(input addr_t ra, input bit d, input addr_t va, input line_t vd);
        bus.in_req_valid   = 1'b1;
        bus.in_req_addr    = ra;
        bus.in_req_dirty   = d;
        bus.in_victim_addr = va;
        bus.in_victim_data = vd;
    endtask

    task automatic do_req(input addr_t ra, input bit d, input addr_t va, input line_t vd, output int acc);
        wait_ready();
        model_req(ra, d, va, vd);
        drive_req(ra, d, va, vd);
        @(posedge clk);
        acc = cyc;
        #1;
        bus.in_req_valid   = 1'b0;
        bus.in_req_addr    = $urandom;
        bus.in_req_dirty   = 1'($urandom);
        bus.in_victim_addr = $urandom;
        bus.in_victim_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_resp(input int acc, input int exp_lat, input string tag);
        int start = n_resp;
        int guard = 0;
        while (n_resp == start && guard < 200) begin
            tick();
            guard++;
        end
        check({tag, "_resp_seen"}, 128'(n_resp - start), 128'(1));
        check({tag, "_latency"}, 128'(last_resp_cyc - acc), 128'(exp_lat));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 128'(bus.out_req_ready), 128'(1));
        check({tag, "_read_en"}, 128'(bus.out_mem_read_en), 128'(0));
        check({tag, "_write_en"}, 128'(bus.out_mem_write_en), 128'(0));
        check({tag, "_resp_valid"}, 128'(bus.out_resp_valid), 128'(0));
        check({tag, "_resp_data"}, bus.out_resp_data, 128'(0));
        check({tag, "_mem_addr"}, 128'(bus.out_mem_addr), 128'(0));
        check({tag, "_wdata"}, bus.out_mem_write_data, 128'(0));
        check({tag, "_timeout_err"}, 128'(bus.out_timeout_err), 128'(0));
    endtask

    initial begin
        int    acc, d, guard, r0, r1, b_acc, rd0, wr0, issue_cyc;
        addr_t ra, va;
        line_t vd;

        bus.in_req_valid     = 1'b0;
        bus.in_req_addr      = '0;
        bus.in_req_dirty     = 1'b0;
        bus.in_victim_addr   = '0;
        bus.in_victim_data   = '0;
        bus.in_mem_ready     = 1'b0;
        bus.in_mem_read_data = '0;
        for (int i = 0; i < 8; i++) begin
            pool[i]          = addr_t'((i + 1) * 32'h100);
            vd               = {$urandom, $urandom, $urandom, $urandom};
            mem[pool[i]]     = vd;
            ref_mem[pool[i]] = vd;
        end

        #2 reset = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Spurious memory ready while idle must be ignored.
        spur = 1'b1;
        repeat (4) tick();
        check("spur_req_ready", 128'(bus.out_req_ready), 128'(1));
        check("spur_no_resp", 128'(n_resp), 128'(0));
        check("spur_no_en", 128'(n_rd + n_wr), 128'(0));

        // Clean miss: offset bits dropped, refill from 0x100.
        lat = 12;
        do_req(32'h0000_0107, 1'b0, 32'h0, '0, acc);
        wait_resp(acc, lat + 2, "clean");
        check("clean_reads", 128'(n_rd), 128'(1));
        check("clean_writes", 128'(n_wr), 128'(0));
        tick();
        check("clean_back_idle", 128'(bus.out_req_ready), 128'(1));

        // Dirty miss: writeback of 0x200 then refill of 0x300.
        do_req(32'h0000_0300, 1'b1, 32'h0000_0200, {16{8'hA5}}, acc);
        wait_resp(acc, 2 * lat + 3, "dirty");
        check("dirty_mem_0x200", mem_rd(32'h200), {16{8'hA5}});
        check("dirty_writes", 128'(n_wr), 128'(1));
        check("dirty_reads", 128'(n_rd), 128'(2));

        // Back-to-back: second request held valid while the first is in flight.
        rd0 = n_rd;
        r0  = n_resp;
        wait_ready();
        model_req(32'h0000_0609, 1'b0, 32'h0, '0);
        drive_req(32'h0000_0609, 1'b0, 32'h0, '0);
        @(posedge clk);
        #1;
        model_req(32'h0000_0703, 1'b0, 32'h0, '0);
        drive_req(32'h0000_0703, 1'b0, 32'h0, '0);
        r1    = -1;
        b_acc = -1;
        guard = 0;
        while (n_resp < r0 + 2 && guard < 300) begin
            tick();
            guard++;
            if (n_resp == r0 + 1 && r1 < 0) r1 = cyc;
            if (bus.in_req_valid && bus.out_req_ready) begin
                b_acc = cyc;
                @(posedge clk);
                #1 bus.in_req_valid = 1'b0;
            end
        end
        check("b2b_both_resp", 128'(n_resp - r0), 128'(2));
        check("b2b_accept_after_resp", 128'(b_acc), 128'(r1 + 1));
        check("b2b_two_reads", 128'(n_rd - rd0), 128'(2));
        check("b2b_second_issue", 128'(last_rd_cyc), 128'(r1 + 2));

        // Random misses over a small pool so writebacks feed later refills.
        for (int i = 0; i < 25; i++) begin
            lat = $urandom_range(1, 15);
            ra  = pool[$urandom_range(0, 7)] | addr_t'($urandom_range(0, 15));
            va  = pool[$urandom_range(0, 7)] | addr_t'($urandom_range(0, 15));
            d   = $urandom_range(0, 1);
            vd  = {$urandom, $urandom, $urandom, $urandom};
            do_req(ra, d[0], va, vd, acc);
            wait_resp(acc, (d != 0) ? 2 * lat + 3 : lat + 2, "rand");
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 3) == 0) begin
                spur = 1'b1;
                tick();
            end
        end
        for (int i = 0; i < 8; i++) check("pool_contents", mem_rd(pool[i]), ref_rd(pool[i]));
        check("no_timeout_yet", 128'(bus.out_timeout_err), 128'(0));

        // Timeout: memory never answers.
        lat      = 12;
        mem_dead = 1'b1;
        rd0      = n_rd;
        r0       = n_resp;
        do_req(32'h0000_0440, 1'b0, 32'h0, '0, acc);
        guard = 0;
        while (n_rd == rd0 && guard < 10) begin
            tick();
            guard++;
        end
        check("to_issue_seen", 128'(n_rd - rd0), 128'(1));
        issue_cyc = cyc;
        while (cyc < issue_cyc + TO) tick();
        check("to_err_before", 128'(bus.out_timeout_err), 128'(0));
        tick();
        check("to_err_set", 128'(bus.out_timeout_err), 128'(1));
        repeat (20) tick();
        check("to_err_sticky", 128'(bus.out_timeout_err), 128'(1));
        check("to_still_busy", 128'(bus.out_req_ready), 128'(0));
        check("to_no_resp", 128'(n_resp - r0), 128'(0));
        check("to_single_read", 128'(n_rd - rd0), 128'(1));

        // Reset while stuck waiting.
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_stuck");
        exp_ops.delete();
        exp_resp.delete();
        mem_dead = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        rd0   = n_rd;
        r0    = n_resp;
        repeat (5) tick();
        check("rst_stuck_no_en", 128'(n_rd + n_wr), 128'(rd0 + n_wr));
        check("rst_stuck_no_resp", 128'(n_resp), 128'(r0));

        // Reset while a live read is pending in memory.
        do_req(32'h0000_0500, 1'b0, 32'h0, '0, acc);
        repeat (4) tick();
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_live");
        exp_ops.delete();
        exp_resp.delete();
        rd0 = n_rd;
        wr0 = n_wr;
        r0  = n_resp;
        repeat (2) tick();
        reset = 1'b1;
        repeat (20) tick();
        check("rst_live_no_read", 128'(n_rd), 128'(rd0));
        check("rst_live_no_write", 128'(n_wr), 128'(wr0));
        check("rst_live_no_resp", 128'(n_resp), 128'(r0));
        check("rst_live_idle", 128'(bus.out_req_ready), 128'(1));

        // Normal operation resumes after reset.
        do_req(32'h0000_010C, 1'b0, 32'h0, '0, acc);
        wait_resp(acc, lat + 2, "post_reset");
        tick();
        check("ops_drained", 128'(exp_ops.size()), 128'(0));
        check("resps_drained", 128'(exp_resp.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
